// File: rtl/cpu_arb_pkg.sv
// cpu_arb_pkg: arbiter state encoding and counter widths shared by the bus arbiter files
package cpu_arb_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQUEST = 3'd1,
        SETTLE  = 3'd2,
        OWN     = 3'd3,
        YIELD   = 3'd4,
        HOLDOFF = 3'd5
    } arb_state_t;
    localparam int TEN_W  = 8;
    localparam int WAIT_W = 8;
    localparam int HOLD_W = 4;
endpackage

// File: rtl/dma_bus_arbiter_if.sv
// dma_bus_arbiter_if: DMA-side handshake plus 68030 arbitration pins seen by the arbiter
interface dma_bus_arbiter_if;
    logic BREQ, CYCLEDONE, BGRANT, TENURE_EXP, ARB_ERR;
    logic nBG, nAS_IN, nDSACK0, nDSACK1, nBGACK_IN;
    logic nBR, nBGACK, BGACK_OE;
    modport slave (
        input  BREQ, CYCLEDONE, nBG, nAS_IN, nDSACK0, nDSACK1, nBGACK_IN,
        output nBR, nBGACK, BGACK_OE, BGRANT, TENURE_EXP, ARB_ERR
    );
    modport master (
        output BREQ, CYCLEDONE, nBG, nAS_IN, nDSACK0, nDSACK1, nBGACK_IN,
        input  nBR, nBGACK, BGACK_OE, BGRANT, TENURE_EXP, ARB_ERR
    );
endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for active-low bus inputs, resetting to the inactive (all ones) level
module sync2 #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         nRESET,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge CLK or negedge nRESET)
        if (!nRESET) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: acquires 68030 bus mastership for SCSI DMA with bounded tenure and hold-off gap
module dma_bus_arbiter #(
    parameter int MAX_TENURE = 64,
    parameter int HOLDOFF    = 4,
    parameter int BG_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRESET,
    dma_bus_arbiter_if.slave  bus
);
    import cpu_arb_pkg::*;

    localparam logic [TEN_W-1:0]  ten_max   = TEN_W'(MAX_TENURE);
    localparam logic [HOLD_W-1:0] hold_last = HOLD_W'(HOLDOFF - 1);
    localparam logic [WAIT_W-1:0] wait_last = WAIT_W'(BG_TIMEOUT - 1);

    arb_state_t        state, nxt;
    logic [TEN_W-1:0]  ten_cnt, ten_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              s_nbg, s_nas, s_ndsack0, s_ndsack1, s_nbgack;
    logic              bus_idle, in_req, in_own, in_hold, err_nxt;

    sync2 #(.W(5)) u_sync (
        .CLK    (CLK),
        .nRESET (nRESET),
        .d      ({bus.nBG, bus.nAS_IN, bus.nDSACK0, bus.nDSACK1, bus.nBGACK_IN}),
        .q      ({s_nbg, s_nas, s_ndsack0, s_ndsack1, s_nbgack})
    );

    assign bus_idle = s_nas & s_ndsack0 & s_ndsack1 & s_nbgack;

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:                 nxt = bus.BREQ ? REQUEST : IDLE;
            REQUEST:              nxt = !bus.BREQ ? IDLE : !s_nbg ? SETTLE : REQUEST;
            SETTLE:               nxt = !bus.BREQ ? IDLE : bus_idle ? OWN : SETTLE;
            OWN:                  nxt = (bus.CYCLEDONE && (!bus.BREQ || ten_cnt == ten_max)) ? YIELD : OWN;
            YIELD:                nxt = cpu_arb_pkg::HOLDOFF;
            cpu_arb_pkg::HOLDOFF: nxt = (hold_cnt == hold_last) ? IDLE : cpu_arb_pkg::HOLDOFF;
            default:              nxt = IDLE;
        endcase
    end

    // counters only run while the FSM stays in their state and restart from zero on entry
    assign in_req   = state == REQUEST && nxt == REQUEST;
    assign in_own   = state == OWN && nxt == OWN;
    assign in_hold  = state == cpu_arb_pkg::HOLDOFF && nxt == cpu_arb_pkg::HOLDOFF;
    assign wait_nxt = in_req ? wait_cnt + WAIT_W'(wait_cnt != '1) : '0;
    assign ten_nxt  = in_own ? ten_cnt + TEN_W'(ten_cnt != ten_max) : '0;
    assign hold_nxt = in_hold ? hold_cnt + HOLD_W'(1) : '0;
    assign err_nxt  = bus.BREQ && (bus.ARB_ERR || (in_req && wait_cnt >= wait_last));

    always_ff @(posedge CLK or negedge nRESET)
        if (!nRESET) begin
            state          <= IDLE;
            ten_cnt        <= '0;
            wait_cnt       <= '0;
            hold_cnt       <= '0;
            bus.nBR        <= 1'b1;
            bus.nBGACK     <= 1'b1;
            bus.BGACK_OE   <= 1'b0;
            bus.BGRANT     <= 1'b0;
            bus.TENURE_EXP <= 1'b0;
            bus.ARB_ERR    <= 1'b0;
        end else begin
            state          <= nxt;
            ten_cnt        <= ten_nxt;
            wait_cnt       <= wait_nxt;
            hold_cnt       <= hold_nxt;
            bus.nBR        <= !(nxt == REQUEST || nxt == SETTLE);
            bus.nBGACK     <= nxt != OWN;
            bus.BGACK_OE   <= nxt == OWN || nxt == YIELD;
            bus.BGRANT     <= nxt == OWN;
            bus.TENURE_EXP <= state == OWN && nxt == YIELD && ten_cnt == ten_max;
            bus.ARB_ERR    <= err_nxt;
        end
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter: directed bench for dma_bus_arbiter with MAX_TENURE=8, HOLDOFF=4, BG_TIMEOUT=10
module tb_dma_bus_arbiter;
    logic CLK = 1'b0;
    logic nRESET = 1'b1;
    int   vectors = 0;
    int   errs = 0;

    dma_bus_arbiter_if bus();

    dma_bus_arbiter #(.MAX_TENURE(8), .HOLDOFF(4), .BG_TIMEOUT(10)) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    // expected pattern order: {nBR, nBGACK, BGACK_OE, BGRANT, TENURE_EXP, ARB_ERR}
    localparam logic [5:0] O_IDLE = 6'b110000;
    localparam logic [5:0] O_REQ  = 6'b010000;
    localparam logic [5:0] O_OWN  = 6'b101100;
    localparam logic [5:0] O_YLD  = 6'b111000;
    localparam logic [5:0] O_YEXP = 6'b111010;
    localparam logic [5:0] O_RERR = 6'b010001;

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {bus.nBR, bus.nBGACK, bus.BGACK_OE, bus.BGRANT, bus.TENURE_EXP, bus.ARB_ERR};
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        bus.BREQ = 0; bus.CYCLEDONE = 0; bus.nBG = 1; bus.nAS_IN = 1;
        bus.nDSACK0 = 1; bus.nDSACK1 = 1; bus.nBGACK_IN = 1;
        #1 nRESET = 0;
        #1 chk("reset_async", O_IDLE);
        tick(2);
        chk("reset_held", O_IDLE);
        nRESET = 1;
        // basic grant, c0 = this cycle
        bus.BREQ = 1;
        tick();   chk("grant_c1_req", O_REQ);
        tick(4);  chk("grant_c5_req", O_REQ);
        bus.nBG = 0;
        tick(2);  chk("grant_c7_req", O_REQ);
        tick();   chk("grant_c8_settle", O_REQ);
        tick();   chk("grant_c9_own", O_OWN);
        // forced yield: tenure reaches 8 at c17, CYCLEDONE low c17..c19
        tick(8);  chk("tenure_c17_own", O_OWN);
        bus.nBG = 1;
        tick();   chk("tenure_c18_own", O_OWN);
        tick();   chk("tenure_c19_own", O_OWN);
        bus.CYCLEDONE = 1;
        tick();   chk("tenure_c20_yield_exp", O_YEXP);
        tick();   chk("holdoff_c21", O_IDLE);
        tick(3);  chk("holdoff_c24", O_IDLE);
        tick();   chk("idle_c25", O_IDLE);
        tick();   chk("rereq_c26", O_REQ);
        // grant timeout: REQUEST from c26, tenth REQUEST cycle is c35
        tick(9);  chk("timeout_c35_noerr", O_REQ);
        tick();   chk("timeout_c36_err", O_RERR);
        tick(3);  chk("timeout_c39_sticky", O_RERR);
        bus.BREQ = 0;
        tick();   chk("timeout_clear_idle", O_IDLE);
        // bus busy: nAS_IN low until c20, new c0 = this cycle
        bus.BREQ = 1; bus.nBG = 0; bus.nAS_IN = 0;
        tick();   chk("busy_c1_req", O_REQ);
        tick(19); chk("busy_c20_settle", O_REQ);
        bus.nAS_IN = 1;
        tick();   chk("busy_c21_settle", O_REQ);
        tick();   chk("busy_c22_settle", O_REQ);
        tick();   chk("busy_c23_own", O_OWN);
        // voluntary release, then BREQ during hold-off is ignored
        bus.BREQ = 0;
        tick();   chk("release_yield", O_YLD);
        tick();   chk("release_holdoff1", O_IDLE);
        bus.BREQ = 1;
        tick(3);  chk("release_holdoff4", O_IDLE);
        tick();   chk("release_idle", O_IDLE);
        tick();   chk("release_rereq", O_REQ);
        // withdrawn request while in SETTLE
        tick();   chk("withdraw_settle", O_REQ);
        bus.BREQ = 0;
        tick();   chk("withdraw_idle", O_IDLE);
        tick();   chk("withdraw_stay_idle", O_IDLE);
        // BREQ drop coincides with tenure expiry
        bus.BREQ = 1; bus.CYCLEDONE = 0;
        tick(3);  chk("coinc_own", O_OWN);
        tick(8);  chk("coinc_tenure8", O_OWN);
        bus.BREQ = 0; bus.CYCLEDONE = 1;
        tick();   chk("coinc_yield_exp", O_YEXP);
        tick(5);  chk("coinc_idle", O_IDLE);
        // reset in the middle of OWN
        bus.BREQ = 1;
        tick(3);  chk("midreset_own", O_OWN);
        #1 nRESET = 0;
        #1 chk("midreset_async", O_IDLE);
        tick();   chk("midreset_held", O_IDLE);
        nRESET = 1;
        tick();   chk("midreset_rereq", O_REQ);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Obtains 68030 bus mastership on behalf of the SCSI DMA CPU-side state machine. Performs the BR/BG/BGACK handshake and waits for the bus to go idle before granting.
- Bounds each DMA tenure so the CPU is not starved, and enforces a hold-off gap between tenures.
- Sits between the DMA state machine (BREQ/BGRANT/CYCLEDONE) and the physical 68030 arbitration pins.

Parameters:
MAX_TENURE, 64, owned-bus cycles before a forced yield (counter width 8 bits, 2..255)
HOLDOFF, 4, cycles after release before a new request may assert nBR (1..15)
BG_TIMEOUT, 255, cycles in REQUEST without synced nBG low before ARB_ERR sets (1..255)

Ports:
CLK  in  1  system clock; one clock domain
nRESET  in  1  asynchronous, active-low reset
BREQ  in  1  bus request from DMA state machine; level, held while bus needed
CYCLEDONE  in  1  DMA state machine has no bus cycle in progress
nBG  in  1  68030 bus grant (async)
nAS_IN  in  1  68030 address strobe (async)
nDSACK0  in  1  data/size ack 0 (async)
nDSACK1  in  1  data/size ack 1 (async)
nBGACK_IN  in  1  wired BGACK as seen on bus (async, other masters)
nBR  out  1  bus request to 68030
nBGACK  out  1  bus grant ack value
BGACK_OE  out  1  output enable for nBGACK pad (open-drain emulation)
BGRANT  out  1  bus owned; DMA state machine may start cycles
TENURE_EXP  out  1  one-cycle pulse on forced yield
ARB_ERR  out  1  sticky grant-timeout flag; cleared when BREQ low

Behaviour:
- Reset (async): state IDLE. nBR=1, nBGACK=1, BGACK_OE=0, BGRANT=0, TENURE_EXP=0, ARB_ERR=0. Counters and synchronisers are cleared; synchronisers reset to 1. Mid-operation reset releases the bus immediately.
- Async inputs nBG, nAS_IN, nDSACK0/1, nBGACK_IN pass through 2-flop synchronisers. The FSM uses only synced values, so it reacts on the 3rd rising edge after an input change.
- All outputs are registered, decoded from the next state, and valid in the cycle the state is entered.
- IDLE: if BREQ=1 -> REQUEST (nBR=0 next cycle).
- REQUEST: nBR=0; wait counter increments.
  - BREQ=0 -> IDLE, nBR=1.
  - Synced nBG=0 -> SETTLE.
  - Wait count reaching BG_TIMEOUT sets ARB_ERR and stays in REQUEST.
- SETTLE: nBR=0; wait for synced nAS_IN=1, nDSACK0=1, nDSACK1=1 and nBGACK_IN=1 in the same cycle.
  - When all hold -> OWN.
  - BREQ=0 -> IDLE without asserting BGACK.
- OWN: nBGACK=0, BGACK_OE=1, nBR=1, BGRANT=1. Tenure counter starts at 0 and increments each cycle, saturating at MAX_TENURE.
  - BREQ=0 and CYCLEDONE=1 -> YIELD.
  - Tenure=MAX_TENURE and CYCLEDONE=1 -> YIELD with TENURE_EXP pulse.
  - Yield never occurs while CYCLEDONE=0; the forced yield waits for it.
  - If BREQ drop and tenure expiry coincide, TENURE_EXP still pulses.
- YIELD: one cycle. BGRANT=0, nBGACK=1 (actively driven high), BGACK_OE=1.
- HOLDOFF: BGACK_OE=0, nBR=1. Counts HOLDOFF cycles, then -> IDLE. BREQ is ignored during hold-off.
- ARB_ERR: set only in REQUEST; cleared on the cycle BREQ is sampled 0.
- Unused state encodings -> IDLE with outputs at reset values.

Decomposition:
- Package cpu_arb_pkg: state enum (IDLE, REQUEST, SETTLE, OWN, YIELD, HOLDOFF; 3-bit encoding) and counter-width constants.
- Sub-module sync2: parameterised-width 2-flop synchroniser with async reset to all ones, instantiated once for the 5 bus inputs.

Test Plan:
- Basic grant: BREQ=1 at cycle 0, nBG low at cycle 5, bus idle -> nBR=0 from cycle 1. OWN entered at cycle 9 with nBGACK=0, BGACK_OE=1, BGRANT=1 and nBR=1 that same cycle.
- Bus busy: nBG low but nAS_IN low until cycle 20 -> stays in SETTLE. OWN entered 3 edges after nAS_IN rises; BGRANT=0 throughout the wait.
- Forced yield, MAX_TENURE=8: BREQ held, CYCLEDONE=0 at tenure 8 for 3 cycles, then 1 -> YIELD only after CYCLEDONE=1. TENURE_EXP is a single pulse, then nBGACK high for 1 cycle, then BGACK_OE=0 for 4 cycles, and nBR reasserts on the 6th cycle after YIELD.
- Withdrawn request: BREQ=1 then 0 while in SETTLE -> IDLE. nBGACK never asserted; nBR=1 next cycle.
- Timeout, BG_TIMEOUT=10: nBG held high -> ARB_ERR=1 after 10 REQUEST cycles and stays set. BREQ=0 clears it and returns to IDLE.
- Reset mid-OWN: nRESET low asynchronously -> nBGACK=1, BGACK_OE=0, BGRANT=0, nBR=1 immediately, without waiting for a clock edge.
